// File: rtl/pipeline_stage_buffer.sv
// pipeline_stage_buffer
//   Parametrised inter-stage pipeline register with a valid/ready handshake,
//   an optional two-entry skid buffer, a synchronous flush and a saturating
//   back-pressure cycle counter. All state updates happen on the falling
//   clock edge, matching the other pipeline registers of the core.
//
// Handshake: a payload moves upstream->buffer when up_valid_in & up_ready_out
//   and buffer->downstream when down_valid_out & down_ready_in, both sampled
//   at the falling clock edge. A presented payload is not retracted until it
//   is taken, and down_payload_out is held stable while stalled.
//
// Ports:
//   clk               stage clock (state updates on negedge)
//   reset             asynchronous, active-high reset
//   flush_in          synchronous flush, drops held and incoming entries
//   up_valid_in       upstream presents a payload
//   up_payload_in     upstream payload
//   up_ready_out      buffer can accept this cycle
//   down_valid_out    down_payload_out is valid
//   down_payload_out  head payload (NOP_PAYLOAD when empty)
//   down_ready_in     downstream accepts the head this cycle
//   occupancy_out     held entries: 0 EMPTY, 1 BUSY, 2 FULL (doubles as FSM state view)
//   stall_cycles_out  saturating count of back-pressured edges
module pipeline_stage_buffer #(
    parameter int                       PAYLOAD_WIDTH   = 128,
    parameter logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD     = '0,
    parameter int                       SKID_ENABLE     = 1,
    parameter int                       STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_in,
    input  logic                       up_valid_in,
    input  logic [PAYLOAD_WIDTH-1:0]   up_payload_in,
    output logic                       up_ready_out,
    output logic                       down_valid_out,
    output logic [PAYLOAD_WIDTH-1:0]   down_payload_out,
    input  logic                       down_ready_in,
    output logic [1:0]                 occupancy_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state;
    logic [PAYLOAD_WIDTH-1:0]   main_q;
    logic [PAYLOAD_WIDTH-1:0]   skid_q;
    logic                       valid_q;
    logic                       ready_q;
    logic [1:0]                 occ_q;
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    logic push;
    logic pop;

    // With the skid buffer, ready is a flop (low only in FULL) so the
    // upstream path does not see down_ready_in combinationally. Without it,
    // a held entry can be replaced in the same cycle it is taken.
    assign up_ready_out = (SKID_ENABLE != 0) ? ready_q : (~valid_q | down_ready_in);

    assign push = up_valid_in & up_ready_out;
    assign pop  = valid_q & down_ready_in;

    assign down_valid_out   = valid_q;
    assign down_payload_out = main_q;
    assign occupancy_out    = occ_q;
    assign stall_cycles_out = stall_q;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            main_q  <= NOP_PAYLOAD;
            skid_q  <= NOP_PAYLOAD;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= 2'd0;
            stall_q <= '0;
        end else begin
            // Back-pressure accounting is independent of flush: a stalled
            // head on the flush edge still counts.
            if (valid_q && !down_ready_in && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_ONE;
            end

            if (flush_in) begin
                state   <= ST_EMPTY;
                main_q  <= NOP_PAYLOAD;
                skid_q  <= NOP_PAYLOAD;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
                occ_q   <= 2'd0;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (push) begin
                            state   <= ST_BUSY;
                            main_q  <= up_payload_in;
                            valid_q <= 1'b1;
                            ready_q <= 1'b1;
                            occ_q   <= 2'd1;
                        end
                    end

                    ST_BUSY: begin
                        if (push && pop) begin
                            // Zero-bubble streaming: head replaced in place.
                            main_q <= up_payload_in;
                        end else if (push) begin
                            // Only reachable with the skid buffer: without it
                            // ready is low whenever the head is stalled.
                            state   <= ST_FULL;
                            skid_q  <= up_payload_in;
                            ready_q <= 1'b0;
                            occ_q   <= 2'd2;
                        end else if (pop) begin
                            state   <= ST_EMPTY;
                            main_q  <= NOP_PAYLOAD;
                            valid_q <= 1'b0;
                            occ_q   <= 2'd0;
                        end
                    end

                    ST_FULL: begin
                        // ready is low here, so only a pop can happen.
                        if (pop) begin
                            state   <= ST_BUSY;
                            main_q  <= skid_q;
                            skid_q  <= NOP_PAYLOAD;
                            ready_q <= 1'b1;
                            occ_q   <= 2'd1;
                        end
                    end

                    default: begin
                        state   <= ST_EMPTY;
                        main_q  <= NOP_PAYLOAD;
                        skid_q  <= NOP_PAYLOAD;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        occ_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Bench for pipeline_stage_buffer: one skid instance (4-bit stall counter,
// non-zero bubble encoding) and one non-skid instance, both checked every
// cycle against a queue-based model of the buffer contents.
module tb_pipeline_stage_buffer;

    localparam int W = 16;
    localparam logic [W-1:0] NOP0 = 16'h5A5A;
    localparam logic [W-1:0] NOP1 = 16'h0000;

    // clock / reset
    logic clk = 1'b1;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance 0: skid buffer
    logic         fl0 = 1'b0, uv0 = 1'b0, dr0 = 1'b1;
    logic [W-1:0] pl0 = '0;
    logic         ur0, dv0;
    logic [W-1:0] dp0;
    logic [1:0]   occ0;
    logic [3:0]   st0;

    // instance 1: no skid buffer
    logic         fl1 = 1'b0, uv1 = 1'b0, dr1 = 1'b1;
    logic [W-1:0] pl1 = '0;
    logic         ur1, dv1;
    logic [W-1:0] dp1;
    logic [1:0]   occ1;
    logic [15:0]  st1;

    pipeline_stage_buffer #(
        .PAYLOAD_WIDTH(W), .NOP_PAYLOAD(NOP0), .SKID_ENABLE(1), .STALL_CNT_WIDTH(4)
    ) u_skid (
        .clk(clk), .reset(reset), .flush_in(fl0),
        .up_valid_in(uv0), .up_payload_in(pl0), .up_ready_out(ur0),
        .down_valid_out(dv0), .down_payload_out(dp0), .down_ready_in(dr0),
        .occupancy_out(occ0), .stall_cycles_out(st0)
    );

    pipeline_stage_buffer #(
        .PAYLOAD_WIDTH(W), .NOP_PAYLOAD(NOP1), .SKID_ENABLE(0), .STALL_CNT_WIDTH(16)
    ) u_noskid (
        .clk(clk), .reset(reset), .flush_in(fl1),
        .up_valid_in(uv1), .up_payload_in(pl1), .up_ready_out(ur1),
        .down_valid_out(dv1), .down_payload_out(dp1), .down_ready_in(dr1),
        .occupancy_out(occ1), .stall_cycles_out(st1)
    );

    // scoreboard / reference model
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int stall_m[2]   = '{0, 0};
    int stall_max[2] = '{15, 65535};
    int skid_en[2]   = '{1, 0};
    int checks = 0;
    int errors = 0;

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [W-1:0] q_front(input int k);
        if (k == 0) return exp_q0[0];
        return exp_q1[0];
    endfunction

    task automatic q_push(input int k, input logic [W-1:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic q_pop(input int k);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic q_clear(input int k);
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // One cycle of checking and model update for one instance. All values are
    // sampled on the rising edge, half a cycle away from the active edge.
    task automatic step(input int k, input logic rst, input logic fl,
                        input logic uv, input logic dr, input logic [W-1:0] pl,
                        input logic dv, input logic ur, input logic [W-1:0] dp,
                        input logic [1:0] occ, input logic [31:0] stall,
                        input logic [W-1:0] nop);
        int  sz;
        logic ev, er, do_push, do_pop;
        if (rst) begin
            check("rst_valid", k, 32'(dv), 32'd0);
            check("rst_ready", k, 32'(ur), 32'd1);
            check("rst_payload", k, 32'(dp), 32'(nop));
            check("rst_occ", k, 32'(occ), 32'd0);
            check("rst_stall", k, stall, 32'd0);
            q_clear(k);
            stall_m[k] = 0;
        end else begin
            sz = q_size(k);
            ev = (sz > 0);
            er = (skid_en[k] != 0) ? (sz < 2) : ((sz == 0) || dr);
            check("valid", k, 32'(dv), 32'(ev));
            check("ready", k, 32'(ur), 32'(er));
            check("occ", k, 32'(occ), 32'(sz));
            check("stall", k, stall, 32'(stall_m[k]));
            if (ev) check("head", k, 32'(dp), 32'(q_front(k)));
            else    check("bubble", k, 32'(dp), 32'(nop));

            do_push = uv && er;
            do_pop  = ev && dr;
            if (ev && !dr && (stall_m[k] < stall_max[k])) stall_m[k]++;
            if (fl) begin
                q_clear(k);
            end else begin
                if (do_pop)  q_pop(k);
                if (do_push) q_push(k, pl);
            end
        end
    endtask

    // monitor
    always @(posedge clk) begin
        step(0, reset, fl0, uv0, dr0, pl0, dv0, ur0, dp0, occ0, 32'(st0), NOP0);
        step(1, reset, fl1, uv1, dr1, pl1, dv1, ur1, dp1, occ1, 32'(st1), NOP1);
    end

    // driver tasks: inputs change 2 time units after the falling edge
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic drive0(input logic v, input logic [W-1:0] p, input logic r, input logic f);
        uv0 = v; pl0 = p; dr0 = r; fl0 = f;
        tick();
    endtask

    task automatic drive1(input logic v, input logic [W-1:0] p, input logic r, input logic f);
        uv1 = v; pl1 = p; dr1 = r; fl1 = f;
        tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;

        // streaming A1..A8 at full rate
        for (int i = 1; i <= 8; i++) drive0(1'b1, 16'(16'hA0 + i), 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);

        // fill the skid: A1 then A2 with downstream stalled; A3 must be refused
        drive0(1'b1, 16'hA1, 1'b0, 1'b0);
        drive0(1'b1, 16'hA2, 1'b0, 1'b0);
        drive0(1'b1, 16'hA3, 1'b0, 1'b0);
        drive0(1'b1, 16'hA3, 1'b0, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);

        // flush while FULL with a payload on the input
        drive0(1'b1, 16'hB1, 1'b0, 1'b0);
        drive0(1'b1, 16'hB2, 1'b0, 1'b0);
        drive0(1'b1, 16'hB0, 1'b0, 1'b1);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);

        // asynchronous reset between edges while FULL
        drive0(1'b1, 16'hC7, 1'b0, 1'b0);
        drive0(1'b1, 16'hC8, 1'b0, 1'b0);
        uv0 = 1'b0;
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        drive0(1'b1, 16'hC1, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);

        // back-pressure: 5 stalled cycles, then on to saturation at 15
        drive0(1'b1, 16'h0011, 1'b0, 1'b0);
        uv0 = 1'b0;
        repeat (22) tick();
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);

        // non-skid instance: stall then same-edge replacement
        drive1(1'b1, 16'hD1, 1'b0, 1'b0);
        drive1(1'b1, 16'hD2, 1'b0, 1'b0);
        drive1(1'b1, 16'hD2, 1'b1, 1'b0);
        drive1(1'b0, 16'h0, 1'b0, 1'b0);
        drive1(1'b0, 16'h0, 1'b1, 1'b0);
        drive1(1'b1, 16'hD3, 1'b1, 1'b1);
        drive1(1'b0, 16'h0, 1'b1, 1'b0);

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            uv0 = 1'($urandom_range(0, 1));
            pl0 = 16'($urandom);
            dr0 = ($urandom_range(0, 3) != 0);
            fl0 = ($urandom_range(0, 31) == 0);
            uv1 = 1'($urandom_range(0, 1));
            pl1 = 16'($urandom);
            dr1 = ($urandom_range(0, 2) != 0);
            fl1 = ($urandom_range(0, 31) == 0);
            tick();
        end

        // drain
        uv0 = 1'b0; dr0 = 1'b1; fl0 = 1'b0;
        uv1 = 1'b0; dr1 = 1'b1; fl1 = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
